// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the phase sequencer / RAM side and mem_access_ctrl.
// Carries the fetch and data request channels, the RAM port and the
// response/status signals.
// Optional: MEM_ACCESS_STATS_EN adds fetchCount/loadCount/storeCount.
// Modports:
//   slave  - the controller (takes requests and memQ, drives RAM port and responses)
//   master - the sequencer/RAM environment (drives requests and memQ)
interface mem_access_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  // Request side
  logic                  fetchReq;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic                  dataReq;
  logic                  dataWrite;
  logic [ADDR_WIDTH-1:0] dataAddr;
  logic [DATA_WIDTH-1:0] writeData;
  // RAM port
  logic [DATA_WIDTH-1:0] memQ;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memData;
  logic                  memWren;
  // Responses and status
  logic [DATA_WIDTH-1:0] fetchData;
  logic                  fetchValid;
  logic [DATA_WIDTH-1:0] loadData;
  logic                  loadValid;
  logic                  storeDone;
  logic                  busy;
  logic                  reqError;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0]           fetchCount;
  logic [15:0]           loadCount;
  logic [15:0]           storeCount;

  modport slave (
    input  fetchReq, fetchAddr, dataReq, dataWrite, dataAddr, writeData, memQ,
    output memAddress, memData, memWren, fetchData, fetchValid, loadData,
           loadValid, storeDone, busy, reqError, fetchCount, loadCount, storeCount
  );
  modport master (
    output fetchReq, fetchAddr, dataReq, dataWrite, dataAddr, writeData, memQ,
    input  memAddress, memData, memWren, fetchData, fetchValid, loadData,
           loadValid, storeDone, busy, reqError, fetchCount, loadCount, storeCount
  );
`else
  modport slave (
    input  fetchReq, fetchAddr, dataReq, dataWrite, dataAddr, writeData, memQ,
    output memAddress, memData, memWren, fetchData, fetchValid, loadData,
           loadValid, storeDone, busy, reqError
  );
  modport master (
    output fetchReq, fetchAddr, dataReq, dataWrite, dataAddr, writeData, memQ,
    input  memAddress, memData, memWren, fetchData, fetchValid, loadData,
           loadValid, storeDone, busy, reqError
  );
`endif
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: serialises instruction fetches (PC) and data
// loads/stores (DR) onto one single-port synchronous RAM with registered
// address, write data and write enable. Each request gets a one-cycle
// valid/done pulse; busy lets the sequencer stall; reqError is sticky.
// Optional: MEM_ACCESS_STATS_EN adds saturating 16-bit operation counters.
// Ports:
//   i_clock  - system clock, rising edge
//   i_resetN - asynchronous active-low reset
//   bus      - mem_access_ctrl_if.slave (requests, RAM port, responses)
// READ_LATENCY: RAM edges from registered address to valid memQ, legal 1..7.
module mem_access_ctrl #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic              i_clock,
  input logic              i_resetN,
  mem_access_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                r_state,        w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,          w_cnt_nxt;
  logic                  r_is_fetch,     w_is_fetch_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_address,  w_mem_address_nxt;
  logic [DATA_WIDTH-1:0] r_mem_data,     w_mem_data_nxt;
  logic                  r_mem_wren,     w_mem_wren_nxt;
  logic [DATA_WIDTH-1:0] r_fetch_data,   w_fetch_data_nxt;
  logic                  r_fetch_valid,  w_fetch_valid_nxt;
  logic [DATA_WIDTH-1:0] r_load_data,    w_load_data_nxt;
  logic                  r_load_valid,   w_load_valid_nxt;
  logic                  r_store_done,   w_store_done_nxt;
  logic                  r_busy,         w_busy_nxt;
  logic                  r_req_error,    w_req_error_nxt;
  logic                  w_any_req;

  assign w_any_req = bus.fetchReq | bus.dataReq;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_is_fetch_nxt    = r_is_fetch;
    w_mem_address_nxt = r_mem_address;
    w_mem_data_nxt    = r_mem_data;
    w_mem_wren_nxt    = 1'b0;
    w_fetch_data_nxt  = r_fetch_data;
    w_fetch_valid_nxt = 1'b0;
    w_load_data_nxt   = r_load_data;
    w_load_valid_nxt  = 1'b0;
    w_store_done_nxt  = 1'b0;
    w_req_error_nxt   = r_req_error;

    case (r_state)
      S_IDLE: begin
        if (bus.dataReq) begin
          // Data channel has priority; a coincident fetch is dropped and flagged
          w_mem_address_nxt = bus.dataAddr;
          w_is_fetch_nxt    = 1'b0;
          if (bus.fetchReq) w_req_error_nxt = 1'b1;
          if (bus.dataWrite) begin
            w_mem_data_nxt = bus.writeData;
            w_mem_wren_nxt = 1'b1;
            w_state_nxt    = S_WRITE;
          end else begin
            w_cnt_nxt   = CNT_W'(READ_LATENCY);
            w_state_nxt = S_READ;
          end
        end else if (bus.fetchReq) begin
          w_mem_address_nxt = bus.fetchAddr;
          w_is_fetch_nxt    = 1'b1;
          w_cnt_nxt         = CNT_W'(READ_LATENCY);
          w_state_nxt       = S_READ;
        end
      end
      S_READ: begin
        if (w_any_req) w_req_error_nxt = 1'b1;
        // Counter hits zero in the cycle memQ is valid for the held address
        if (r_cnt == '0) begin
          if (r_is_fetch) begin
            w_fetch_data_nxt  = bus.memQ;
            w_fetch_valid_nxt = 1'b1;
          end else begin
            w_load_data_nxt  = bus.memQ;
            w_load_valid_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (w_any_req) w_req_error_nxt = 1'b1;
        w_store_done_nxt = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_is_fetch    <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
      r_load_data   <= '0;
      r_load_valid  <= 1'b0;
      r_store_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_req_error   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_is_fetch    <= w_is_fetch_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_data    <= w_mem_data_nxt;
      r_mem_wren    <= w_mem_wren_nxt;
      r_fetch_data  <= w_fetch_data_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_load_data   <= w_load_data_nxt;
      r_load_valid  <= w_load_valid_nxt;
      r_store_done  <= w_store_done_nxt;
      r_busy        <= w_busy_nxt;
      r_req_error   <= w_req_error_nxt;
    end
  end

  assign bus.memAddress = r_mem_address;
  assign bus.memData    = r_mem_data;
  assign bus.memWren    = r_mem_wren;
  assign bus.fetchData  = r_fetch_data;
  assign bus.fetchValid = r_fetch_valid;
  assign bus.loadData   = r_load_data;
  assign bus.loadValid  = r_load_valid;
  assign bus.storeDone  = r_store_done;
  assign bus.busy       = r_busy;
  assign bus.reqError   = r_req_error;

`ifdef MEM_ACCESS_STATS_EN
  logic [STAT_W-1:0] r_fetch_cnt, w_fetch_cnt_nxt;
  logic [STAT_W-1:0] r_load_cnt,  w_load_cnt_nxt;
  logic [STAT_W-1:0] r_store_cnt, w_store_cnt_nxt;

  // Saturating counters advance together with their completion pulse
  always_comb begin
    w_fetch_cnt_nxt = r_fetch_cnt;
    w_load_cnt_nxt  = r_load_cnt;
    w_store_cnt_nxt = r_store_cnt;
    if (w_fetch_valid_nxt && (r_fetch_cnt != '1)) w_fetch_cnt_nxt = r_fetch_cnt + STAT_W'(1);
    if (w_load_valid_nxt  && (r_load_cnt  != '1)) w_load_cnt_nxt  = r_load_cnt  + STAT_W'(1);
    if (w_store_done_nxt  && (r_store_cnt != '1)) w_store_cnt_nxt = r_store_cnt + STAT_W'(1);
  end

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_fetch_cnt <= '0;
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
    end else begin
      r_fetch_cnt <= w_fetch_cnt_nxt;
      r_load_cnt  <= w_load_cnt_nxt;
      r_store_cnt <= w_store_cnt_nxt;
    end
  end

  assign bus.fetchCount = r_fetch_cnt;
  assign bus.loadCount  = r_load_cnt;
  assign bus.storeCount = r_store_cnt;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: one instance at READ_LATENCY=1
// with a writable RAM model and a response scoreboard, and one instance at
// READ_LATENCY=3 with a read-only RAM model for the latency/busy checks.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus1 ();
  mem_access_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus3 ();

  mem_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .READ_LATENCY(1)) u_dut1 (
    .i_clock(clk), .i_resetN(rst_n), .bus(bus1)
  );
  mem_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .READ_LATENCY(3)) u_dut3 (
    .i_clock(clk), .i_resetN(rst_n), .bus(bus3)
  );

  // Power-on RAM image
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h5A5A);
  endfunction

  // Latency-1 writable RAM
  logic [15:0] ram1 [256];
  bit          wr1  [256];
  logic [15:0] q1;
  always @(posedge clk) begin
    q1 <= wr1[bus1.memAddress[7:0]] ? ram1[bus1.memAddress[7:0]] : init_val(bus1.memAddress);
    if (bus1.memWren) begin
      ram1[bus1.memAddress[7:0]] <= bus1.memData;
      wr1[bus1.memAddress[7:0]]  <= 1'b1;
    end
  end
  assign bus1.memQ = q1;

  // Latency-3 read-only RAM
  logic [15:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= init_val(bus3.memAddress);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.memQ = p3[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard of expected completions for the latency-1 instance
  typedef struct {
    logic [2:0]  kind;   // onehot {store, load, fetch}
    logic [15:0] data;
    int          at;
  } exp_t;
  localparam logic [2:0] K_FETCH = 3'b001;
  localparam logic [2:0] K_LOAD  = 3'b010;
  localparam logic [2:0] K_STORE = 3'b100;

  exp_t sb_q[$];
  int   exp_f = 0, exp_l = 0, exp_s = 0;

  task automatic push_exp(input logic [2:0] kind, input logic [15:0] data, input int lat);
    exp_t e;
    e.kind = kind; e.data = data; e.at = cyc + lat;
    sb_q.push_back(e);
    if (kind == K_FETCH) exp_f++;
    else if (kind == K_LOAD) exp_l++;
    else exp_s++;
  endtask

  always @(negedge clk) begin
    logic [2:0] obs;
    exp_t       e;
    obs = {bus1.storeDone, bus1.loadValid, bus1.fetchValid};
    if (obs != 3'b000) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_pulse", 64'(obs), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_kind", 64'(obs), 64'(e.kind));
        check_eq("sb_cycle", 64'(cyc), 64'(e.at));
        if (e.kind == K_FETCH) check_eq("sb_fetch_data", 64'(bus1.fetchData), 64'(e.data));
        if (e.kind == K_LOAD)  check_eq("sb_load_data",  64'(bus1.loadData),  64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.fetchReq = 1'b0; bus1.dataReq = 1'b0; bus1.dataWrite = 1'b0;
    bus1.fetchAddr = '0;  bus1.dataAddr = '0;  bus1.writeData = '0;
    bus3.fetchReq = 1'b0; bus3.dataReq = 1'b0; bus3.dataWrite = 1'b0;
    bus3.fetchAddr = '0;  bus3.dataAddr = '0;  bus3.writeData = '0;
  endtask

  // Each request task drives for the current cycle and returns one cycle later
  task automatic do_fetch1(input logic [15:0] a);
    bus1.fetchReq = 1'b1; bus1.fetchAddr = a;
    tick();
    bus1.fetchReq = 1'b0;
  endtask

  task automatic do_data1(input logic wr, input logic [15:0] a, input logic [15:0] d);
    bus1.dataReq = 1'b1; bus1.dataWrite = wr; bus1.dataAddr = a; bus1.writeData = d;
    tick();
    bus1.dataReq = 1'b0; bus1.dataWrite = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick();
    repeat (3) tick();
    check_eq(tag, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb_q.delete();
    exp_f = 0; exp_l = 0; exp_s = 0;
  endtask

  initial begin
    int   c0;
    bit   seen;
    bit   wren_seen;
    int   vcyc;
    logic [15:0] vdata;

    // Reset with random inputs: every output stays 0
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus1.fetchReq  = 1'($urandom); bus1.dataReq = 1'($urandom);
      bus1.dataWrite = 1'($urandom); bus1.fetchAddr = 16'($urandom);
      bus1.dataAddr  = 16'($urandom); bus1.writeData = 16'($urandom);
      @(negedge clk);
      check_eq("rst_addr_data", {bus1.memAddress, bus1.memData, bus1.fetchData, bus1.loadData}, 64'd0);
      check_eq("rst_flags", 64'({bus1.memWren, bus1.fetchValid, bus1.loadValid,
                                 bus1.storeDone, bus1.busy, bus1.reqError}), 64'd0);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
    check_eq("post_rst_busy", 64'(bus1.busy), 64'd0);
    check_eq("post_rst_wren_err", 64'({bus1.memWren, bus1.reqError}), 64'd0);

    // Latency 3: fetch, then a store request while busy is ignored
    c0 = cyc;
    bus3.fetchReq = 1'b1; bus3.fetchAddr = 16'h0020;
    tick();
    bus3.fetchReq = 1'b0;
    bus3.dataReq = 1'b1; bus3.dataWrite = 1'b1; bus3.dataAddr = 16'h0030; bus3.writeData = 16'hFFFF;
    @(negedge clk);
    check_eq("l3_c1_busy", 64'(bus3.busy), 64'd1);
    check_eq("l3_c1_addr", 64'(bus3.memAddress), 64'h0020);
    check_eq("l3_c1_err_clear", 64'(bus3.reqError), 64'd0);
    tick();
    bus3.dataReq = 1'b0; bus3.dataWrite = 1'b0;
    seen = 1'b0; wren_seen = 1'b0; vcyc = 0; vdata = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus3.memWren || bus3.storeDone) wren_seen = 1'b1;
      if (bus3.fetchValid) begin
        seen = 1'b1; vcyc = cyc; vdata = bus3.fetchData;
      end
    end
    check_eq("l3_valid_seen", 64'(seen), 64'd1);
    check_eq("l3_valid_cycle", 64'(vcyc - c0), 64'd5);
    check_eq("l3_fetch_data", 64'(vdata), 64'h5A7A);
    check_eq("l3_req_error", 64'(bus3.reqError), 64'd1);
    check_eq("l3_no_store", 64'(wren_seen), 64'd0);
    check_eq("l3_addr_unchanged", 64'(bus3.memAddress), 64'h0020);

    // Latency 1: fetch of 0x10
    tick();
    push_exp(K_FETCH, 16'hA5A5, 3);
    do_fetch1(16'h0010);
    @(negedge clk);
    check_eq("f_c1_addr", 64'(bus1.memAddress), 64'h0010);
    check_eq("f_c1_busy_wren", 64'({bus1.busy, bus1.memWren}), 64'b10);
    tick();
    @(negedge clk);
    check_eq("f_c2_busy", 64'(bus1.busy), 64'd1);
    tick();
    @(negedge clk);
    check_eq("f_c3_busy", 64'(bus1.busy), 64'd0);
    drain("drain_fetch");

    // Store 0x1234 to 0x42, then load it back from the storeDone cycle
    push_exp(K_STORE, 16'h0000, 2);
    do_data1(1'b1, 16'h0042, 16'h1234);
    @(negedge clk);
    check_eq("s_c1_port", {bus1.memAddress, bus1.memData, 31'd0, bus1.memWren},
             {16'h0042, 16'h1234, 31'd0, 1'b1});
    tick();
    @(negedge clk);
    check_eq("s_c2_wren_busy", 64'({bus1.memWren, bus1.busy}), 64'd0);
    push_exp(K_LOAD, 16'h1234, 3);
    do_data1(1'b0, 16'h0042, 16'h0000);
    @(negedge clk);
    check_eq("l_c1_wren", 64'(bus1.memWren), 64'd0);
    drain("drain_store_load");
    check_eq("hold_fetch_data", 64'(bus1.fetchData), 64'hA5A5);
    check_eq("err_still_clear", 64'(bus1.reqError), 64'd0);

    // Coincident fetch and load: load wins, fetch dropped, error flagged
    bus1.fetchReq = 1'b1; bus1.fetchAddr = 16'h0010;
    push_exp(K_LOAD, init_val(16'h0005), 3);
    do_data1(1'b0, 16'h0005, 16'h0000);
    bus1.fetchReq = 1'b0;
    @(negedge clk);
    check_eq("sim_addr", 64'(bus1.memAddress), 64'h0005);
    drain("drain_simul");
    check_eq("sim_req_error", 64'(bus1.reqError), 64'd1);
    check_eq("sim_fetch_hold", 64'(bus1.fetchData), 64'hA5A5);

    // Reset during READ: access abandoned, no pulse
    do_fetch1(16'h0010);
    #2;
    apply_reset();
    #1;
    check_eq("mid_rst_busy_wren", 64'({bus1.busy, bus1.memWren}), 64'd0);
    check_eq("mid_rst_err", 64'(bus1.reqError), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) tick();

    // Reset during WRITE: memWren drops at once, RAM left untouched
    do_data1(1'b1, 16'h0060, 16'h7777);
    check_eq("mid_wr_wren_on", 64'(bus1.memWren), 64'd1);
    apply_reset();
    #1;
    check_eq("mid_wr_wren_off", 64'(bus1.memWren), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    push_exp(K_LOAD, init_val(16'h0060), 3);
    do_data1(1'b0, 16'h0060, 16'h0000);
    drain("drain_after_rst_load");
    push_exp(K_FETCH, 16'hA5A5, 3);
    do_fetch1(16'h0010);
    drain("drain_after_rst_fetch");

`ifdef MEM_ACCESS_STATS_EN
    check_eq("stat_fetch", 64'(bus1.fetchCount), 64'(exp_f));
    check_eq("stat_load",  64'(bus1.loadCount),  64'(exp_l));
    check_eq("stat_store", 64'(bus1.storeCount), 64'(exp_s));
    check_eq("stat3_fetch", 64'(bus3.fetchCount), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Parametrised memory access controller between the CPU phase sequencer and a single-port synchronous RAM. It serialises instruction fetches (PC-addressed) and data loads/stores (DR-addressed) onto one RAM port using registered address, data and write-enable outputs. It supports configurable data/address width and RAM read latency, and gives each request a request/valid handshake with a busy indication so the sequencer can stall.

Parameters:
DATA_WIDTH, 16, width of instruction/data words and RAM data bus
ADDR_WIDTH, 16, width of PC/DR and RAM address bus
READ_LATENCY, 1, RAM clock edges from registered address to valid memQ; legal 1..7

Ports:
clock  in  1  system clock, all state on rising edge
resetN  in  1  asynchronous, active-low reset
fetchReq  in  1  one-cycle pulse: fetch word at fetchAddr
fetchAddr  in  ADDR_WIDTH  program counter
dataReq  in  1  one-cycle pulse: data access at dataAddr
dataWrite  in  1  qualifies dataReq: 1=store, 0=load
dataAddr  in  ADDR_WIDTH  data address (DR)
writeData  in  DATA_WIDTH  store data
memQ  in  DATA_WIDTH  RAM read data
memAddress  out  ADDR_WIDTH  registered RAM address
memData  out  DATA_WIDTH  registered RAM write data
memWren  out  1  registered RAM write enable
fetchData  out  DATA_WIDTH  fetched instruction, held until next fetch completes
fetchValid  out  1  one-cycle pulse, fetchData updated
loadData  out  DATA_WIDTH  loaded word, held until next load completes
loadValid  out  1  one-cycle pulse, loadData updated
storeDone  out  1  one-cycle pulse, store written
busy  out  1  high while a request is in progress
reqError  out  1  sticky: request arrived while busy

Behaviour:
- Reset (resetN=0, async): state IDLE; memAddress, memData, fetchData, loadData = 0; memWren, fetchValid, loadValid, storeDone, busy, reqError = 0; latency counter = 0.
- States: IDLE, READ (address on RAM, counting latency), WRITE (memWren asserted). busy = (state != IDLE).
- IDLE accept: if dataReq, take data request; else if fetchReq, take fetch. Simultaneous fetchReq and dataReq: data wins, fetch is dropped and reqError is set.
- Load/fetch accepted in cycle 0: cycle 1 memAddress = addr, memWren = 0, state READ, counter = READ_LATENCY. Counter decrements each cycle in READ. When counter reaches 0, memQ is captured into fetchData or loadData. In the following cycle the matching valid pulses and state is IDLE.
- Response timing: the valid pulse occurs in cycle 2+READ_LATENCY after the request (READ_LATENCY=1: request cycle 0, valid cycle 3).
- Store accepted in cycle 0: cycle 1 memAddress = dataAddr, memData = writeData, memWren = 1, state WRITE. Cycle 2: memWren = 0, storeDone = 1, state IDLE.
- Back-to-back: busy is low in the valid/storeDone cycle, so a new request is accepted that cycle.
- Request (either) with busy = 1: ignored, no effect on in-flight access, reqError set. reqError clears only on reset.
- memAddress and memData hold their last values in IDLE. memWren is 1 only in WRITE.
- Address and data widths pass straight through; there is no truncation or wrap.
- Reset mid-access: the access is abandoned immediately, memWren drops asynchronously, and no valid/done pulse is issued.

Optional Feature:
MEM_ACCESS_STATS_EN: when defined, adds outputs fetchCount, loadCount, storeCount (each 16 bits, reset 0). Each counter increments by 1 on its fetchValid/loadValid/storeDone pulse and saturates at 16'hFFFF. When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold resetN=0 with random inputs -> all outputs 0, busy=0; release -> still idle.
- Fetch, READ_LATENCY=1: fetchReq, fetchAddr=16'h0010, RAM[0x10]=16'hA5A5 -> memAddress=0x0010 in cycle 1, fetchValid=1 and fetchData=16'hA5A5 in cycle 3, busy high in cycles 1-2.
- Store then load: store 16'h1234 to 0x0042 -> memWren=1 only in cycle 1, storeDone in cycle 2. Load at 0x0042 issued in the storeDone cycle -> loadData=16'h1234 with loadValid 3 cycles later.
- Simultaneous fetchReq and dataReq load at 0x0005 -> load serviced, no fetchValid ever, reqError=1.
- Request during busy; then, with READ_LATENCY=3, fetchReq -> extra request ignored and reqError=1; fetchValid in cycle 5.
- resetN pulsed low during READ -> no fetchValid, memWren=0, next fetch completes normally. With MEM_ACCESS_STATS_EN, counts match the number of completed operations.
